// File: rtl/note_scheduler.sv
// PS/2 note-key scheduler: parses make/break/extended scan codes and keeps a
// last-pressed-priority stack of held notes driving a monophonic tone generator.
module note_scheduler #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       ps2_data,
  input  logic             ps2_valid,
  input  logic             flush,
  output logic [7:0]       note_code,
  output logic             note_on,
  output logic             note_change,
  output logic [CNT_W-1:0] held_count,
  output logic             overflow
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [7:0]       stk_r     [DEPTH];
  logic [7:0]       stk_nxt_s [DEPTH];
  logic             make_s;
  logic             brk_s;
  logic             hit_s;
  logic [CNT_W-1:0] hit_idx_s;
  logic             rm_en_s;
  logic [CNT_W-1:0] rm_idx_s;
  logic             push_en_s;
  logic             ovf_s;
  logic [CNT_W-1:0] base_cnt_s;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic [7:0]       top_s;
  logic             on_nxt_s;

  function automatic logic is_note(input logic [7:0] code);
    case (code)
      8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35,
      8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B: is_note = 1'b1;
      default:                                   is_note = 1'b0;
    endcase
  endfunction

  // Scan-code parser: next state plus make/break action strobes
  always_comb begin
    state_nxt_s = state_r;
    make_s      = 1'b0;
    brk_s       = 1'b0;
    if (ps2_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (ps2_data == 8'hF0) begin
            state_nxt_s = ST_BRK;
          end else if (ps2_data == 8'hE0) begin
            state_nxt_s = ST_EXT;
          end else begin
            state_nxt_s = ST_IDLE;
            make_s      = is_note(ps2_data);
          end
        end
        ST_BRK: begin
          state_nxt_s = ST_IDLE;
          brk_s       = is_note(ps2_data);
        end
        ST_EXT: begin
          if (ps2_data == 8'hF0) begin
            state_nxt_s = ST_EXT_BRK;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_EXT_BRK: state_nxt_s = ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Stack update: every action is "remove one entry (optional), then push on top (optional)"
  always_comb begin
    hit_s     = 1'b0;
    hit_idx_s = CNT_ZERO;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < held_count) && (stk_r[i] == ps2_data)) begin
        hit_s     = 1'b1;
        hit_idx_s = CNT_W'(i);
      end else begin
        hit_s     = hit_s;
      end
    end

    rm_en_s   = 1'b0;
    rm_idx_s  = hit_idx_s;
    push_en_s = 1'b0;
    ovf_s     = 1'b0;
    if (make_s) begin
      push_en_s = 1'b1;
      if (hit_s) begin
        rm_en_s = 1'b1;
      end else if (held_count == CNT_FULL) begin
        // full stack: evict the oldest entry at the bottom
        rm_en_s  = 1'b1;
        rm_idx_s = CNT_ZERO;
        ovf_s    = 1'b1;
      end else begin
        rm_en_s = 1'b0;
      end
    end else if (brk_s && hit_s) begin
      rm_en_s = 1'b1;
    end else begin
      rm_en_s = 1'b0;
    end

    base_cnt_s = held_count - {{(CNT_W-1){1'b0}}, rm_en_s};
    cnt_nxt_s  = base_cnt_s + {{(CNT_W-1){1'b0}}, push_en_s};

    for (int i = 0; i < DEPTH; i++) begin
      stk_nxt_s[i] = stk_r[i];
    end
    for (int i = 0; i < DEPTH - 1; i++) begin
      if (rm_en_s && (CNT_W'(i) >= rm_idx_s)) begin
        stk_nxt_s[i] = stk_r[i+1];
      end else begin
        stk_nxt_s[i] = stk_nxt_s[i];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (push_en_s && (CNT_W'(i) == base_cnt_s)) begin
        stk_nxt_s[i] = ps2_data;
      end else begin
        stk_nxt_s[i] = stk_nxt_s[i];
      end
    end

    // an empty stack keeps the last sounding code
    top_s = note_code;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) + CNT_ONE) == cnt_nxt_s) begin
        top_s = stk_nxt_s[i];
      end else begin
        top_s = top_s;
      end
    end
    on_nxt_s = (cnt_nxt_s != CNT_ZERO);
  end

  // State, stack and registered outputs; flush is the synchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r     <= ST_IDLE;
      held_count  <= CNT_ZERO;
      note_code   <= 8'h00;
      note_on     <= 1'b0;
      note_change <= 1'b0;
      overflow    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        stk_r[i] <= 8'h00;
      end
    end else if (flush) begin
      state_r     <= ST_IDLE;
      held_count  <= CNT_ZERO;
      note_on     <= 1'b0;
      note_change <= note_on;
      overflow    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      held_count  <= cnt_nxt_s;
      note_code   <= top_s;
      note_on     <= on_nxt_s;
      note_change <= (top_s != note_code) || (on_nxt_s != note_on);
      overflow    <= ovf_s;
      for (int i = 0; i < DEPTH; i++) begin
        stk_r[i] <= stk_nxt_s[i];
      end
    end
  end

endmodule
